motion_arbiter: RTL and testbench
=================================

MOTION_ARBITER -- requirements
Module: motion_arbiter

Interface
REQ-001 Parameter DEAD_CYCLES, default 1000000, sets the zero-drive dead time between opposing drive classes; legal range 1..2^24-1.
REQ-002 Parameter NEAR_CM, default 20, sets the obstacle-set threshold in cm.
REQ-003 Parameter FAR_CM, default 25, sets the obstacle-clear threshold in cm; FAR_CM > NEAR_CM.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 enable  in  1  run switch; 0 forces IDLE.
REQ-007 req_valid  in  1  one-cycle request strobe from the navigation FSM.
REQ-008 req_mode  in  5  requested motor mode code.
REQ-009 dist_valid  in  1  one-cycle strobe marking a new ultrasonic sample.
REQ-010 distance  in  20  ultrasonic distance in cm.
REQ-011 mode  out  5  mode driven to the motor block.
REQ-012 last_mode  out  5  value of mode before its most recent change.
REQ-013 grant  out  1  one-cycle pulse, request accepted.
REQ-014 busy  out  1  high in DEAD or HOLD.
REQ-015 obstacle  out  1  registered obstacle flag.
REQ-016 arb_state  out  2  IDLE=0, RUN=1, DEAD=2, HOLD=3.

Function
REQ-017 Mode classes: NONE = {0,1,2,30,31 and any unlisted code}, FWD = {3,4,8,9}, REV = {7}, PIVL = {5}, PIVR = {6}.
REQ-018 Two modes conflict when both are non-NONE and their classes differ.
REQ-019 obstacle sets on dist_valid with 0 < distance < NEAR_CM, and clears on dist_valid with distance >= FAR_CM; a sample of distance==0 is ignored; otherwise obstacle holds its value.
REQ-020 IDLE: mode=0; enable=1 moves to RUN on the next cycle with mode still 0.
REQ-021 RUN, req_valid, no conflict with the current mode, and not (req FWD and obstacle) -> mode<=req_mode next cycle, grant=1.
REQ-022 RUN, req_valid with conflict -> DEAD, mode<=30, pending<=req_mode, counter<=DEAD_CYCLES-1, grant=1.
REQ-023 RUN, req FWD while obstacle=1 -> HOLD, mode<=30, pending<=req_mode, grant=1.
REQ-024 RUN, no request, obstacle=1 and current mode FWD -> HOLD, mode<=30, pending<=current mode.
REQ-025 DEAD: the counter decrements each cycle; req_valid overwrites pending (latest wins) and issues grant.
REQ-026 DEAD, counter==0 -> RUN with mode<=pending; if pending is FWD and obstacle=1, go to HOLD instead and keep pending.
REQ-027 HOLD, req_valid FWD -> pending<=req_mode, grant=1, remain in HOLD.
REQ-028 HOLD, req_valid non-FWD -> RUN, mode<=req_mode, grant=1; no dead time is applied, since mode is 30 (NONE).
REQ-029 HOLD, obstacle=0 and no request -> RUN, mode<=pending.
REQ-030 Priority, highest first: enable=0 > obstacle > req_valid > counter expiry.
REQ-031 enable=0 in any state -> IDLE next cycle: mode=0, pending=0, counter=0, grant=0; obstacle keeps tracking samples.
REQ-032 last_mode<=mode in every cycle where mode changes value; otherwise it holds.
REQ-033 grant is never high in IDLE or when enable=0.
REQ-034 grant is never high for two consecutive cycles without two consecutive req_valid.
REQ-035 All outputs are registered, with no combinational path from input to output.
REQ-036 Latency from req_valid to a mode change is 1 cycle with no conflict, and DEAD_CYCLES+1 cycles with a conflict.

Reset
REQ-037 rst_n=0 asynchronously forces: arb_state=IDLE, mode=0, last_mode=0, grant=0, busy=0, obstacle=0, pending=0, counter=0.
REQ-038 After rst_n rises, the first state update occurs on the next rising clk edge.
REQ-039 Reset asserted mid-DEAD or mid-HOLD discards pending and the count; the motor sees mode 0 immediately.

Verification (bench uses DEAD_CYCLES=4, NEAR_CM=20, FAR_CM=25)
REQ-040 enable=1, req 3 -> grant on the next cycle, mode=3, last_mode=0, busy=0.
REQ-041 mode=3, req 7 -> mode=30 for 4 cycles with busy=1 and arb_state=2, then mode=7, last_mode=30.
REQ-042 mode=3, req 7, then req 5 on the 2nd dead cycle -> two grants, and mode=5 after the count expires.
REQ-043 mode=3, dist_valid with distance=15 -> obstacle=1, mode=30, arb_state=3; next, distance=22 -> no change; next, distance=30 -> mode=3.
REQ-044 In HOLD, req 7 -> mode=7 next cycle, arb_state=1; distance=0 samples leave obstacle unchanged.
REQ-045 Mid-DEAD, pulse rst_n low, or drop enable -> mode=0 immediately (reset) or next cycle (enable), with no stale pending mode emitted afterwards.

Source files
------------

// File: rtl/motion_arbiter.sv
// Motion arbiter: serialises navigation mode requests to the motor block, inserting a
// zero-drive dead time between opposing drive classes and holding forward drive near obstacles.
module motion_arbiter #(
    parameter int unsigned DEAD_CYCLES = 1000000,
    parameter int unsigned NEAR_CM     = 20,
    parameter int unsigned FAR_CM      = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req_valid,
    input  logic [4:0]  req_mode,
    input  logic        dist_valid,
    input  logic [19:0] distance,
    output logic [4:0]  mode,
    output logic [4:0]  last_mode,
    output logic        grant,
    output logic        busy,
    output logic        obstacle,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_FWD,
        CL_REV,
        CL_PIVL,
        CL_PIVR
    } mclass_t;

    localparam logic [4:0]  MODE_STOP  = 5'd0;
    localparam logic [4:0]  MODE_BRAKE = 5'd30;
    localparam logic [19:0] NEAR_C     = 20'(NEAR_CM);
    localparam logic [19:0] FAR_C      = 20'(FAR_CM);
    localparam logic [23:0] DEAD_INIT  = 24'(DEAD_CYCLES - 1);

    function automatic mclass_t class_of(input logic [4:0] m);
        case (m)
            5'd3, 5'd4, 5'd8, 5'd9: class_of = CL_FWD;
            5'd7:                   class_of = CL_REV;
            5'd5:                   class_of = CL_PIVL;
            5'd6:                   class_of = CL_PIVR;
            default:                class_of = CL_NONE;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  mode_q, mode_d;
    logic [4:0]  last_mode_q, last_mode_d;
    logic [4:0]  pending_q, pending_d;
    logic [23:0] counter_q, counter_d;
    logic        grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        obstacle_q, obstacle_d;

    mclass_t     req_cls, cur_cls;
    logic        req_fwd, cur_fwd, conflict;
    logic [4:0]  pending_eff;

    // Hysteresis: set below NEAR, clear at/above FAR, zero-distance samples are dropouts.
    always_comb begin
        obstacle_d = obstacle_q;
        if (dist_valid && (distance != '0)) begin
            if (distance < NEAR_C) begin
                obstacle_d = 1'b1;
            end else if (distance >= FAR_C) begin
                obstacle_d = 1'b0;
            end
        end
    end

    assign req_cls     = class_of(req_mode);
    assign cur_cls     = class_of(mode_q);
    assign req_fwd     = (req_cls == CL_FWD);
    assign cur_fwd     = (cur_cls == CL_FWD);
    assign conflict    = (req_cls != CL_NONE) && (cur_cls != CL_NONE) && (req_cls != cur_cls);
    assign pending_eff = req_valid ? req_mode : pending_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        counter_d = counter_q;
        grant_d   = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            mode_d    = MODE_STOP;
            pending_d = '0;
            counter_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    mode_d  = MODE_STOP;
                end
                RUN: begin
                    if (req_valid && req_fwd && obstacle_q) begin
                        state_d   = HOLD;
                        mode_d    = MODE_BRAKE;
                        pending_d = req_mode;
                        grant_d   = 1'b1;
                    end else if (obstacle_q && cur_fwd) begin
                        // Obstacle outranks any non-forward request arriving the same cycle.
                        state_d   = HOLD;
                        mode_d    = MODE_BRAKE;
                        pending_d = mode_q;
                    end else if (req_valid && conflict) begin
                        state_d   = DEAD;
                        mode_d    = MODE_BRAKE;
                        pending_d = req_mode;
                        counter_d = DEAD_INIT;
                        grant_d   = 1'b1;
                    end else if (req_valid) begin
                        mode_d  = req_mode;
                        grant_d = 1'b1;
                    end
                end
                DEAD: begin
                    grant_d   = req_valid;
                    pending_d = pending_eff;
                    if (counter_q == '0) begin
                        if ((class_of(pending_eff) == CL_FWD) && obstacle_q) begin
                            state_d = HOLD;
                        end else begin
                            state_d   = RUN;
                            mode_d    = pending_eff;
                            pending_d = '0;
                        end
                    end else begin
                        counter_d = counter_q - 24'd1;
                    end
                end
                HOLD: begin
                    if (req_valid && !req_fwd) begin
                        state_d   = RUN;
                        mode_d    = req_mode;
                        pending_d = '0;
                        grant_d   = 1'b1;
                    end else if (req_valid) begin
                        pending_d = req_mode;
                        grant_d   = 1'b1;
                    end else if (!obstacle_q) begin
                        state_d   = RUN;
                        mode_d    = pending_q;
                        pending_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d      = (state_d == DEAD) || (state_d == HOLD);
        last_mode_d = (mode_d != mode_q) ? mode_q : last_mode_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_STOP;
            last_mode_q <= MODE_STOP;
            pending_q   <= '0;
            counter_q   <= '0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            obstacle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            last_mode_q <= last_mode_d;
            pending_q   <= pending_d;
            counter_q   <= counter_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            obstacle_q  <= obstacle_d;
        end
    end

    assign mode      = mode_q;
    assign last_mode = last_mode_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign obstacle  = obstacle_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_motion_arbiter.sv
// Bench for motion_arbiter: directed scenarios then randomized traffic, every cycle compared
// against a cycle-level behavioural model of the arbitration rules.
module tb_motion_arbiter;

    localparam int DEAD = 4;
    localparam int NEAR = 20;
    localparam int FAR  = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        req_valid;
    logic [4:0]  req_mode;
    logic        dist_valid;
    logic [19:0] distance;
    logic [4:0]  mode;
    logic [4:0]  last_mode;
    logic        grant;
    logic        busy;
    logic        obstacle;
    logic [1:0]  arb_state;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 idle, 1 run, 2 dead, 3 hold
    int m_state, m_mode, m_last, m_pend, m_cnt, m_grant, m_busy, m_obs;

    motion_arbiter #(
        .DEAD_CYCLES(DEAD),
        .NEAR_CM    (NEAR),
        .FAR_CM     (FAR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .dist_valid(dist_valid),
        .distance  (distance),
        .mode      (mode),
        .last_mode (last_mode),
        .grant     (grant),
        .busy      (busy),
        .obstacle  (obstacle),
        .arb_state (arb_state)
    );

    always #5 clk = ~clk;

    // 0 none, 1 forward, 2 reverse, 3 pivot left, 4 pivot right
    function automatic int cls(input int m);
        if (m inside {3, 4, 8, 9}) return 1;
        if (m == 7) return 2;
        if (m == 5) return 3;
        if (m == 6) return 4;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode"},      {27'd0, mode},      m_mode);
        check({tag, ".last_mode"}, {27'd0, last_mode}, m_last);
        check({tag, ".grant"},     {31'd0, grant},     m_grant);
        check({tag, ".busy"},      {31'd0, busy},      m_busy);
        check({tag, ".obstacle"},  {31'd0, obstacle},  m_obs);
        check({tag, ".state"},     {30'd0, arb_state}, m_state);
    endtask

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_last = 0; m_pend = 0;
        m_cnt = 0; m_grant = 0; m_busy = 0; m_obs = 0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        int n_state = m_state;
        int n_mode  = m_mode;
        int n_pend  = m_pend;
        int n_cnt   = m_cnt;
        int n_grant = 0;
        int n_obs   = m_obs;
        int rq      = int'(req_mode);
        int d       = int'(distance);

        if (dist_valid && d > 0 && d < NEAR) n_obs = 1;
        if (dist_valid && d >= FAR) n_obs = 0;

        if (!enable) begin
            n_state = 0; n_mode = 0; n_pend = 0; n_cnt = 0;
        end else if (m_state == 0) begin
            n_state = 1; n_mode = 0;
        end else if (m_state == 1) begin
            if (req_valid && cls(rq) == 1 && m_obs == 1) begin
                n_state = 3; n_mode = 30; n_pend = rq; n_grant = 1;
            end else if (m_obs == 1 && cls(m_mode) == 1) begin
                n_state = 3; n_mode = 30; n_pend = m_mode;
            end else if (req_valid) begin
                n_grant = 1;
                if (cls(rq) != 0 && cls(m_mode) != 0 && cls(rq) != cls(m_mode)) begin
                    n_state = 2; n_mode = 30; n_pend = rq; n_cnt = DEAD - 1;
                end else begin
                    n_mode = rq;
                end
            end
        end else if (m_state == 2) begin
            if (req_valid) begin
                n_pend = rq; n_grant = 1;
            end
            if (m_cnt > 0) n_cnt = m_cnt - 1;
            else if (cls(n_pend) == 1 && m_obs == 1) n_state = 3;
            else begin
                n_state = 1; n_mode = n_pend;
            end
        end else begin
            if (req_valid && cls(rq) != 1) begin
                n_state = 1; n_mode = rq; n_grant = 1;
            end else if (req_valid) begin
                n_pend = rq; n_grant = 1;
            end else if (m_obs == 0) begin
                n_state = 1; n_mode = m_pend;
            end
        end

        if (n_mode != m_mode) m_last = m_mode;
        m_state = n_state; m_mode = n_mode; m_pend = n_pend; m_cnt = n_cnt;
        m_grant = n_grant; m_obs = n_obs;
        m_busy  = (n_state >= 2) ? 1 : 0;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic request(input int m);
        req_valid = 1'b1;
        req_mode  = 5'(m);
    endtask

    task automatic sample(input int dcm);
        dist_valid = 1'b1;
        distance   = 20'(dcm);
    endtask

    task automatic quiet();
        req_valid  = 1'b0;
        dist_valid = 1'b0;
    endtask

    initial begin
        int gcount;
        int pick;
        int modes[10] = '{0, 3, 4, 5, 6, 7, 8, 9, 30, 31};

        rst_n = 1'b0; enable = 1'b0; req_valid = 1'b0; req_mode = '0;
        dist_valid = 1'b0; distance = '0;
        model_reset();
        #3;
        check_all("reset");
        #9;
        rst_n = 1'b1;

        // Startup and first uncontested request
        enable = 1'b1;
        step("idle_to_run");
        check("run_mode0", {27'd0, mode}, 0);
        request(3);
        step("req3");
        quiet();
        check("r040_grant", {31'd0, grant}, 1);
        check("r040_mode", {27'd0, mode}, 3);
        check("r040_last", {27'd0, last_mode}, 0);
        check("r040_busy", {31'd0, busy}, 0);

        // Forward to reverse through dead time
        request(7);
        step("req7");
        quiet();
        check("r041_dead_mode", {27'd0, mode}, 30);
        for (int i = 0; i < DEAD - 1; i++) begin
            step("dead");
            check("r041_dead_busy", {31'd0, busy}, 1);
            check("r041_dead_state", {30'd0, arb_state}, 2);
        end
        step("dead_exit");
        check("r041_mode7", {27'd0, mode}, 7);
        check("r041_last30", {27'd0, last_mode}, 30);

        // Back to forward, then latest-wins inside the dead window
        request(3);
        step("req3b");
        quiet();
        for (int i = 0; i < DEAD; i++) step("dead3");
        check("back_to_3", {27'd0, mode}, 3);
        gcount = 0;
        request(7);
        step("r042_req7");
        gcount += int'(grant);
        quiet();
        step("r042_dead1");
        gcount += int'(grant);
        request(5);
        step("r042_req5");
        gcount += int'(grant);
        quiet();
        for (int i = 0; i < 2; i++) begin
            step("r042_tail");
            gcount += int'(grant);
        end
        check("r042_grants", gcount, 2);
        check("r042_mode5", {27'd0, mode}, 5);

        request(3);
        step("to3");
        quiet();
        for (int i = 0; i < DEAD; i++) step("to3_dead");

        // Obstacle hysteresis with forward drive
        sample(15);
        step("obs_set");
        quiet();
        step("obs_hold");
        check("r043_obs", {31'd0, obstacle}, 1);
        check("r043_mode30", {27'd0, mode}, 30);
        check("r043_hold", {30'd0, arb_state}, 3);
        sample(22);
        step("obs_22");
        quiet();
        step("obs_22b");
        check("r043_still30", {27'd0, mode}, 30);
        sample(30);
        step("obs_clear");
        quiet();
        step("obs_resume");
        check("r043_mode3", {27'd0, mode}, 3);

        // Non-forward request escapes HOLD; zero-distance samples ignored
        sample(15);
        step("obs_set2");
        quiet();
        step("hold2");
        sample(0);
        step("zero_sample");
        quiet();
        check("r044_obs_kept", {31'd0, obstacle}, 1);
        request(7);
        step("hold_req7");
        quiet();
        check("r044_mode7", {27'd0, mode}, 7);
        check("r044_run", {30'd0, arb_state}, 1);
        sample(40);
        step("clear2");
        quiet();
        step("idle_run");

        // Reset mid-dead discards the pending mode
        request(3);
        step("pre_rst");
        quiet();
        step("mid_dead");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("r045_rst_mode", {27'd0, mode}, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("post_rst");
            check("r045_no_stale_rst", {27'd0, mode}, 0);
        end

        // Enable drop mid-dead
        request(4);
        step("req4");
        request(7);
        step("req7c");
        quiet();
        step("dead_c");
        enable = 1'b0;
        step("en_low");
        check("r045_en_mode", {27'd0, mode}, 0);
        check("r045_en_state", {30'd0, arb_state}, 0);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("post_en");
            check("r045_no_stale_en", {27'd0, mode}, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 24) != 0);
            req_valid = ($urandom_range(0, 3) == 0);
            pick      = $urandom_range(0, 11);
            req_mode  = (pick < 10) ? 5'(modes[pick]) : 5'($urandom_range(0, 31));
            dist_valid = ($urandom_range(0, 5) == 0);
            pick      = $urandom_range(0, 9);
            distance  = (pick == 0) ? 20'd0 : 20'($urandom_range(1, 45));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
